// File: rtl/systolic_brightness_engine_if.sv
// Bundle of job-control, operand-stream and result-stream signals for systolic_brightness_engine.
// Valid/ready: a beat or row transfers on a rising edge where both valid and ready are high; the presenter holds its data stable until that edge.
interface systolic_brightness_engine_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 40,
  parameter int K_W    = 16,
  parameter int OUT_W  = 16
);
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic [OUT_W:0]         offset;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DATA_W-1:0]    a_col;
  logic [N*DATA_W-1:0]    b_row;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(N)-1:0]   out_row;
  logic [N*ACC_W-1:0]     out_raw;
  logic [N*OUT_W-1:0]     out_norm;
  logic                   busy;
  logic                   done;

  modport master (
    output start, k_len, offset, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_raw, out_norm, busy, done
  );

  modport slave (
    input  start, k_len, offset, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_raw, out_norm, busy, done
  );
endinterface

// File: rtl/systolic_brightness_engine.sv
// NxN output-stationary systolic MAC array with controller; streams normalised result rows.
// Operands enter skewed (lane i delayed i beats), results drain one row per handshake.
module systolic_brightness_engine #(
  parameter int N          = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 40,
  parameter int K_W        = 16,
  parameter int NORM_SHIFT = 8,
  parameter int OUT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  systolic_brightness_engine_if.slave bus,
  output logic [1:0]                  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_e;

  localparam int RW    = $clog2(N);
  localparam int CNT_W = $clog2(2 * N) + 1;
  localparam int T_W   = ACC_W + OUT_W + 2;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic [OUT_W:0]     offset_q, offset_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  a_skew_q [N][N-1];
  logic [DATA_W-1:0]  a_skew_d [N][N-1];
  logic [DATA_W-1:0]  b_skew_q [N][N-1];
  logic [DATA_W-1:0]  b_skew_d [N][N-1];
  logic [DATA_W-1:0]  a_pe_q [N][N];
  logic [DATA_W-1:0]  a_pe_d [N][N];
  logic [DATA_W-1:0]  b_pe_q [N][N];
  logic [DATA_W-1:0]  b_pe_d [N][N];
  logic [ACC_W-1:0]   acc_q [N][N];
  logic [ACC_W-1:0]   acc_d [N][N];

  logic               advance;
  logic [DATA_W-1:0]  a_inj [N];
  logic [DATA_W-1:0]  b_inj [N];
  logic [DATA_W-1:0]  a_edge [N];
  logic [DATA_W-1:0]  b_edge [N];
  logic [DATA_W-1:0]  a_in [N][N];
  logic [DATA_W-1:0]  b_in [N][N];
  logic [T_W-1:0]     t_c [N];
  logic [OUT_W-1:0]   norm_c [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      offset_q    <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
      a_skew_q    <= '{default: '0};
      b_skew_q    <= '{default: '0};
      a_pe_q      <= '{default: '0};
      b_pe_q      <= '{default: '0};
      acc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      offset_q    <= offset_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
      a_skew_q    <= a_skew_d;
      b_skew_q    <= b_skew_d;
      a_pe_q      <= a_pe_d;
      b_pe_q      <= b_pe_d;
      acc_q       <= acc_d;
    end
  end

  // Datapath: the array only moves on an accepted beat or during flush.
  always_comb begin
    a_skew_d = a_skew_q;
    b_skew_d = b_skew_q;
    a_pe_d   = a_pe_q;
    b_pe_d   = b_pe_q;
    acc_d    = acc_q;
    advance  = ((state_q == LOAD) && bus.in_valid) || (state_q == FLUSH);
    for (int i = 0; i < N; i++) begin
      a_inj[i]  = (state_q == LOAD) ? bus.a_col[i*DATA_W +: DATA_W] : '0;
      b_inj[i]  = (state_q == LOAD) ? bus.b_row[i*DATA_W +: DATA_W] : '0;
      a_edge[i] = a_inj[i];
      b_edge[i] = b_inj[i];
      for (int s = 0; s < N - 1; s++) begin
        if (s == i - 1) begin
          a_edge[i] = a_skew_q[i][s];
          b_edge[i] = b_skew_q[i][s];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = (j == 0) ? a_edge[i] : a_pe_q[i][(j > 0) ? j - 1 : 0];
        b_in[i][j] = (i == 0) ? b_edge[j] : b_pe_q[(i > 0) ? i - 1 : 0][j];
      end
    end
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        a_skew_d[i][0] = a_inj[i];
        b_skew_d[i][0] = b_inj[i];
        for (int s = 1; s < N - 1; s++) begin
          a_skew_d[i][s] = a_skew_q[i][s-1];
          b_skew_d[i][s] = b_skew_q[i][s-1];
        end
        for (int j = 0; j < N; j++) begin
          a_pe_d[i][j] = a_in[i][j];
          b_pe_d[i][j] = b_in[i][j];
          acc_d[i][j]  = acc_q[i][j] + ACC_W'({{DATA_W{1'b0}}, a_in[i][j]} *
                                              {{DATA_W{1'b0}}, b_in[i][j]});
        end
      end
    end
    if ((state_q == IDLE) && bus.start) begin
      a_skew_d = '{default: '0};
      b_skew_d = '{default: '0};
      a_pe_d   = '{default: '0};
      b_pe_d   = '{default: '0};
      acc_d    = '{default: '0};
    end
  end

  // FLUSH exits after 2N-2 propagation cycles plus one, so the far PE's last product lands first.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    k_cnt_d     = k_cnt_q;
    offset_d    = offset_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_len_d     = bus.k_len;
          offset_d    = bus.offset;
          k_cnt_d     = '0;
          flush_cnt_d = '0;
          state_d     = (bus.k_len == '0) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          k_cnt_d = k_cnt_q + K_W'(1);
          if (k_cnt_q == k_len_q - K_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (flush_cnt_q == CNT_W'(2 * N - 2)) begin
          row_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(N - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Normalisation in a width that can neither wrap nor lose the offset sign.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      t_c[j] = T_W'(acc_q[row_q][j] >> NORM_SHIFT) +
               {{(T_W - OUT_W - 1){offset_q[OUT_W]}}, offset_q};
      if (t_c[j][T_W-1]) begin
        norm_c[j] = '0;
      end else if (|t_c[j][T_W-2:OUT_W]) begin
        norm_c[j] = '1;
      end else begin
        norm_c[j] = t_c[j][OUT_W-1:0];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign bus.out_raw[j*ACC_W +: ACC_W]  = acc_q[row_q][j];
    assign bus.out_norm[j*OUT_W +: OUT_W] = norm_c[j];
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_row   = row_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_systolic_brightness_engine.sv
// Directed self-checking bench for systolic_brightness_engine (N=4 defaults).
// Expected rows come from a bench-side matrix product queued in exp_q.
module tb_systolic_brightness_engine;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 40;
  localparam int K_W    = 16;
  localparam int OUT_W  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [ACC_W-1:0] exp_q[$];

  systolic_brightness_engine_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W), .OUT_W(OUT_W)) bus ();

  systolic_brightness_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W),
                               .NORM_SHIFT(8), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] a_val(input int mode, input int i, input int k);
    if (mode == 0) return 8'd255;
    return (i == k) ? 8'd16 : 8'd0;
  endfunction

  function automatic logic [DATA_W-1:0] b_val(input int mode, input int k, input int j);
    if (mode == 0) return 8'd255;
    return DATA_W'(k + 4 * j);
  endfunction

  function automatic longint norm_model(input longint raw, input int off);
    longint t;
    t = (raw >> 8) + longint'(off);
    if (t < 0) return 0;
    if (t > 65535) return 65535;
    return t;
  endfunction

  // driver tasks
  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.offset    = '0;
    bus.in_valid  = 1'b0;
    bus.a_col     = '0;
    bus.b_row     = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic start_job(input int k, input int off);
    logic [31:0] off_v;
    off_v      = off;
    bus.k_len  = K_W'(k);
    bus.offset = off_v[OUT_W:0];
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic send_beat(input int mode, input int kk);
    int cnt;
    for (int i = 0; i < N; i++) begin
      bus.a_col[i*DATA_W +: DATA_W] = a_val(mode, i, kk);
      bus.b_row[i*DATA_W +: DATA_W] = b_val(mode, kk, i);
    end
    bus.in_valid = 1'b1;
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input int mode, input int k, input int off,
                         input bit gaps, input bit stall, input bit poke);
    int cnt;
    int d0;
    longint sum;
    logic [ACC_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += longint'(a_val(mode, i, kk)) * longint'(b_val(mode, kk, j));
        exp_q.push_back(ACC_W'(sum));
      end
    d0 = done_cnt;
    start_job(k, off);
    if (poke) begin
      bus.start = 1'b1;
      bus.k_len = K_W'(3);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int kk = 0; kk < k; kk++) begin
      if (gaps && kk == 2) begin
        repeat (3) @(posedge clk);
        #1;
      end
      send_beat(mode, kk);
    end
    cnt = 0;
    while (!bus.out_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (k > 0) check("latency", cnt, 2 * N - 1);
    else if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    // scoreboard drain
    for (int r = 0; r < N; r++) begin
      cnt = 0;
      while (!bus.out_valid && cnt < 50) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (!bus.out_valid) check("row_timeout", r, N);
      if (stall && r == 1) begin
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_valid", bus.out_valid, 1);
          check("stall_row", bus.out_row, r);
          check("stall_raw3", bus.out_raw[3*ACC_W +: ACC_W], exp_q[3]);
        end
      end
      check("out_row", bus.out_row, r);
      for (int j = 0; j < N; j++) begin
        e = exp_q.pop_front();
        check("out_raw", bus.out_raw[j*ACC_W +: ACC_W], e);
        check("out_norm", bus.out_norm[j*OUT_W +: OUT_W], norm_model(longint'(e), off));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    @(posedge clk); #1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_job(0, 4, 0, 1'b0, 1'b0, 1'b0);
    run_job(0, 4, 100, 1'b0, 1'b0, 1'b0);
    run_job(0, 4, -2000, 1'b0, 1'b0, 1'b0);
    run_job(0, 255, 1000, 1'b0, 1'b0, 1'b0);
    run_job(1, 4, 7, 1'b1, 1'b1, 1'b0);
    run_job(0, 0, 50, 1'b0, 1'b0, 1'b1);

    // abort a job mid-LOAD with reset, then rerun the baseline job
    start_job(4, 100);
    send_beat(0, 0);
    send_beat(0, 1);
    check("midload_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_raw0", bus.out_raw[ACC_W-1:0], 0);
    check("abort_norm0", bus.out_norm[OUT_W-1:0], 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 4, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
